// File: rtl/sram_1024x32_wb_if.sv
// Wishbone B4 classic slave bundle for the weight SRAM.
// The master modport drives requests and the slave modport returns ack and read data.
interface sram_1024x32_wb_if #(
  parameter int DW = 32
);
  logic            wbs_stb_i;
  logic            wbs_cyc_i;
  logic            wbs_we_i;
  logic [DW/8-1:0] wbs_sel_i;
  logic [DW-1:0]   wbs_dat_i;
  logic [31:0]     wbs_adr_i;
  logic            wbs_ack_o;
  logic [DW-1:0]   wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sram_1024x32_wb.sv
// 1024x32 single-port weight SRAM with a Wishbone slave, byte-lane writes and a one-cycle ack pulse.
// Define SRAM_OUT_REG_EN to add an output register stage, which gives a two-cycle ack and read latency.
module sram_1024x32_wb #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int ADDR_LSB = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  sram_1024x32_wb_if.slave    wbs
);
  localparam int NB = DW / 8;

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] idx;
  logic          req;
  logic          accept;
  logic          ack_q;
  logic [DW-1:0] dat_q;

  // Only the index bits are decoded. Higher address bits alias onto the same words.
  assign idx = wbs.wbs_adr_i[ADDR_LSB +: AW];
  assign req = wbs.wbs_stb_i & wbs.wbs_cyc_i;

  logic unused_adr;
  assign unused_adr = ^wbs.wbs_adr_i;

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

`ifdef SRAM_OUT_REG_EN
  logic          pend_q;
  logic          pend_rd_q;
  logic [DW-1:0] rd_q;

  // No new request is taken while one is still in the pipe or being acked.
  assign accept = req & ~ack_q & ~pend_q;

  // NOTE: the array has no reset and keeps its contents through reset, so a write already sampled still commits.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      if (wbs.wbs_we_i) begin
        for (int b = 0; b < NB; b++)
          if (wbs.wbs_sel_i[b]) mem[idx][8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
      end else begin
        rd_q <= mem[idx];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments, so every flop samples values from before the edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      pend_q    <= 1'b0;
      pend_rd_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      pend_q <= accept;
      if (accept) pend_rd_q <= ~wbs.wbs_we_i;
      ack_q <= pend_q;
      if (pend_q && pend_rd_q) dat_q <= rd_q;
    end
  end
`else
  // While ack is high the held strobe is not taken again, which limits the rate to one transfer every two cycles.
  assign accept = req & ~ack_q;

  // NOTE: the array has no reset and keeps its contents through reset, so a write already sampled still commits.
  always_ff @(posedge wb_clk_i) begin
    if (accept && wbs.wbs_we_i) begin
      for (int b = 0; b < NB; b++)
        if (wbs.wbs_sel_i[b]) mem[idx][8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
    end
  end

  // NOTE: all state uses non-blocking assignments, so every flop samples values from before the edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      if (accept && !wbs.wbs_we_i) dat_q <= mem[idx];
    end
  end
`endif
endmodule

// File: tb/tb_sram_1024x32_wb.sv
// Randomised self-checking bench for sram_1024x32_wb. A word-array model holds the expected contents.
// Directed cases cover reset, byte lanes, held strobe, address alias and reset mid-transfer.
module tb_sram_1024x32_wb;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
  localparam int STREAM_PULSES = 2;
`else
  localparam int LAT = 1;
  localparam int STREAM_PULSES = 3;
`endif

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b0;

  sram_1024x32_wb_if wb ();

  sram_1024x32_wb dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs      (wb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] last_rd;
  logic [9:0]  pool [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  task automatic idle();
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
  endtask

  // One handshake, started and finished on a falling edge.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdat;
    wb.wbs_sel_i = sel;
    n = 0;
    do begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      n++;
    end while (wb.wbs_ack_o !== 1'b1 && n < 8);
    check("ack_latency", n, LAT);
    rdat = wb.wbs_dat_o;
    idle();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("ack_one_cycle", {31'b0, wb.wbs_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    logic [31:0] m;
    m = lane_mask(sel);
    ref_mem[adr[9:0]] = (ref_mem[adr[9:0]] & ~m) | (d & m);
    xfer(1'b1, adr, d, sel, r);
    check("wr_dat_hold", r, last_rd);
  endtask

  task automatic rd(input logic [31:0] adr, input string tag);
    logic [31:0] r;
    xfer(1'b0, adr, $urandom, 4'($urandom), r);
    check(tag, r, ref_mem[adr[9:0]]);
    last_rd = ref_mem[adr[9:0]];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic exp_ack;
    wb.wbs_adr_i = 32'd5;
    wb.wbs_dat_i = '0;
    idle();
    last_rd = '0;

    // Reset is held with a live request, so nothing may respond.
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge wb_clk_i);
      check("rst_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
      check("rst_dat", wb.wbs_dat_o, 32'd0);
    end
    idle();
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);

    // Basic write and read, then byte lanes.
    wr(32'd5, 32'hDEADBEEF, 4'hF);
    rd(32'd5, "rd_word5");
    wr(32'd7, 32'h11223344, 4'hF);
    wr(32'd7, 32'hAABBCCDD, 4'h5);
    rd(32'd7, "rd_lanes");
    check("lanes_const", ref_mem[7], 32'h11BB33DD);
    wr(32'd7, 32'hFFFFFFFF, 4'h0);
    rd(32'd7, "rd_sel0");

    // A strobe without cyc, or cyc without a strobe, is not a request.
    wb.wbs_stb_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge wb_clk_i);
      check("no_cyc_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge wb_clk_i);
      check("no_stb_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    end
    idle();

    // Held read strobe on the top word: periodic single-cycle acks.
    wr(32'h3FF, 32'h12345678, 4'hF);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_adr_i = 32'h3FF;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      exp_ack = (k % (LAT + 1)) == LAT;
      check("stream_ack", {31'b0, wb.wbs_ack_o}, {31'b0, exp_ack});
      if (wb.wbs_ack_o === 1'b1) begin
        pulses++;
        check("stream_dat", wb.wbs_dat_o, 32'h12345678);
      end
    end
    check("stream_pulses", pulses, STREAM_PULSES);
    last_rd = 32'h12345678;
    idle();
    repeat (2) @(negedge wb_clk_i);

    // An address above the index range aliases onto word 0.
    wr(32'h400, 32'hCAFEF00D, 4'hF);
    rd(32'h000, "rd_alias");
    rd(32'd1023, "rd_top");

    // Random traffic over a pool of fully initialised words, with upper address bits as noise.
    for (int i = 0; i < 16; i++) begin
      pool[i] = 10'(i * 61 + 11);
      wr({22'($urandom), pool[i]}, $urandom, 4'hF);
    end
    for (int i = 0; i < 48; i++) begin
      logic [9:0] w;
      w = pool[$urandom_range(15)];
      if ($urandom_range(1) == 1) wr({22'($urandom), w}, $urandom, 4'($urandom));
      else                        rd({22'($urandom), w}, "rd_rand");
    end

    // A write sampled just before reset still commits.
    @(negedge wb_clk_i);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_adr_i = 32'd9;
    wb.wbs_dat_i = 32'h0BADF00D;
    wb.wbs_sel_i = 4'hF;
    ref_mem[9] = 32'h0BADF00D;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    idle();
    @(negedge wb_clk_i);
    check("rstw_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rstw_dat", wb.wbs_dat_o, 32'd0);
    wb_rst_i = 1'b1;
    last_rd = '0;
    @(negedge wb_clk_i);
    rd(32'd9, "rd_after_rstw");

    // Reset asserted in the cycle the read ack would rise.
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 32'd7;
    repeat (LAT) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge wb_clk_i);
      check("rstr_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
      check("rstr_dat", wb.wbs_dat_o, 32'd0);
    end
    wb_rst_i = 1'b1;
    last_rd = '0;
    @(negedge wb_clk_i);
    check("post_rst_idle", {31'b0, wb.wbs_ack_o}, 32'd0);
    rd(32'd5, "rd_after_rstr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
